// File: rtl/dw_window_gen_if.sv
// Pixel-stream and window-stream bundle for the depthwise 3x3 window generator.
// The producer (master) drives the pixel beats; the generator (slave) drives windows back.
interface dw_window_gen_if #(
   parameter int CH = 16,
   parameter int DW = 8
);
   logic                  in_valid;
   logic [CH*DW-1:0]      in_act;
   logic                  out_valid;
   logic [9*CH*DW-1:0]    out_window;
   logic                  frame_done;

   modport master (
      output in_valid,
      output in_act,
      input  out_valid,
      input  out_window,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  in_act,
      output out_valid,
      output out_window,
      output frame_done
   );
endinterface

// File: rtl/dw_window_gen.sv
// Sliding 3x3 window generator: two line buffers plus a 3x3 register window,
// emitting one flat multi-channel window per valid position (stride 1 or 2).
module dw_window_gen #(
   parameter int CH     = 16,
   parameter int DW     = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int STRIDE = 1
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           soft_clr,
   dw_window_gen_if.slave bus
);
   localparam int PW = CH * DW;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [PW-1:0] lb0_r [IMG_W];
   logic [PW-1:0] lb1_r [IMG_W];
   logic [PW-1:0] win_r [9];
   logic          out_valid_r;
   logic          frame_done_r;

   logic          accept_s;
   logic          col_wrap_s;
   logic          row_wrap_s;
   logic          pos_ok_s;
   logic          stride_ok_s;
   logic          emit_s;
   logic [PW-1:0] lb0_rd_s;
   logic [PW-1:0] lb1_rd_s;

   // Beat acceptance, wrap detection, emission decision and line-buffer read
   always_comb begin
      accept_s   = bus.in_valid & ~soft_clr;
      col_wrap_s = (col_r == COL_LAST);
      row_wrap_s = (row_r == ROW_LAST);
      pos_ok_s   = (row_r >= RW'(2)) && (col_r >= CW'(2));
      // (r-2) and (c-2) even is the same as r and c even
      if (STRIDE == 2) begin
         stride_ok_s = ~row_r[0] & ~col_r[0];
      end else begin
         stride_ok_s = 1'b1;
      end
      emit_s   = accept_s & pos_ok_s & stride_ok_s;
      lb0_rd_s = lb0_r[col_r];
      lb1_rd_s = lb1_r[col_r];
   end

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_r <= '0;
         row_r <= '0;
      end else if (soft_clr) begin
         col_r <= '0;
         row_r <= '0;
      end else if (accept_s) begin
         if (col_wrap_s) begin
            col_r <= '0;
            row_r <= row_wrap_s ? '0 : row_r + RW'(1);
         end else begin
            col_r <= col_r + CW'(1);
            row_r <= row_r;
         end
      end else begin
         col_r <= col_r;
         row_r <= row_r;
      end
   end

   // Registered strobes, one cycle after the deciding beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else if (soft_clr) begin
         out_valid_r  <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         out_valid_r  <= emit_s;
         frame_done_r <= accept_s & col_wrap_s & row_wrap_s;
      end
   end

   // 3x3 window: shift each row left, load the new column from the buffers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 9; k++) begin
            win_r[k] <= '0;
         end
      end else if (accept_s) begin
         for (int ky = 0; ky < 3; ky++) begin
            win_r[ky*3]     <= win_r[ky*3 + 1];
            win_r[ky*3 + 1] <= win_r[ky*3 + 2];
         end
         win_r[2] <= lb1_rd_s;
         win_r[5] <= lb0_rd_s;
         win_r[8] <= bus.in_act;
      end else begin
         for (int k = 0; k < 9; k++) begin
            win_r[k] <= win_r[k];
         end
      end
   end

   // Line buffers age by one row per accepted pixel; contents are never reset
   always_ff @(posedge clk) begin
      if (accept_s) begin
         lb1_r[col_r] <= lb0_rd_s;
         lb0_r[col_r] <= bus.in_act;
      end
   end

   // Repack window: channel-major, then tap k = ky*3+kx
   for (genvar c = 0; c < CH; c++) begin : g_ch
      for (genvar k = 0; k < 9; k++) begin : g_tap
         assign bus.out_window[c*9*DW + k*DW +: DW] = win_r[k][c*DW +: DW];
      end
   end

   assign bus.out_valid  = out_valid_r;
   assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_dw_window_gen.sv
// Randomized bench for dw_window_gen: stride-1 and stride-2 instances share one
// stimulus stream and are compared each cycle against an image-based window model.
module tb_dw_window_gen;
   localparam int CH = 16;
   localparam int DW = 8;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int PW = CH * DW;
   localparam int WW = 9 * PW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          soft_clr = 1'b0;
   logic          in_valid = 1'b0;
   logic [PW-1:0] in_act = '0;

   always #5 clk = ~clk;

   dw_window_gen_if #(.CH(CH), .DW(DW)) bus1 ();
   dw_window_gen_if #(.CH(CH), .DW(DW)) bus2 ();

   assign bus1.in_valid = in_valid;
   assign bus1.in_act   = in_act;
   assign bus2.in_valid = in_valid;
   assign bus2.in_act   = in_act;

   dw_window_gen #(.CH(CH), .DW(DW), .IMG_W(W), .IMG_H(H), .STRIDE(1)) dut1 (
      .clk      (clk),
      .rstn     (rstn),
      .soft_clr (soft_clr),
      .bus      (bus1)
   );

   dw_window_gen #(.CH(CH), .DW(DW), .IMG_W(W), .IMG_H(H), .STRIDE(2)) dut2 (
      .clk      (clk),
      .rstn     (rstn),
      .soft_clr (soft_clr),
      .bus      (bus2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [PW-1:0] img [H][W];
   int            m_row = 0;
   int            m_col = 0;
   logic          exp_v1, exp_v2, exp_fd, exp_wchk;
   logic [WW-1:0] exp_w = '0;
   int            pulses1 = 0;
   int            pulses2 = 0;
   logic [WW-1:0] first_w1 = '0;
   logic [WW-1:0] second_w2 = '0;
   int            taps0 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [PW-1:0] pix(input int r, input int c, input int off);
      logic [PW-1:0] p;
      for (int ch = 0; ch < CH; ch++) begin
         p[ch*DW +: DW] = DW'(((8*r + c + ch) % 128) + off);
      end
      return p;
   endfunction

   function automatic logic [PW-1:0] rpx();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // One clock: apply inputs, predict from the image model, check at the next negedge
   task automatic step(input logic v, input logic clr, input logic [PW-1:0] px);
      in_valid = v;
      soft_clr = clr;
      in_act   = px;
      exp_v1 = 1'b0; exp_v2 = 1'b0; exp_fd = 1'b0; exp_wchk = 1'b0;
      if (!rstn) begin
         m_row = 0; m_col = 0; exp_w = '0; exp_wchk = 1'b1;
      end else if (clr) begin
         m_row = 0; m_col = 0;
      end else if (v) begin
         img[m_row][m_col] = px;
         if (m_row >= 2 && m_col >= 2) begin
            exp_v1   = 1'b1;
            exp_wchk = 1'b1;
            exp_v2   = ((m_row - 2) % 2 == 0) && ((m_col - 2) % 2 == 0);
            for (int ch = 0; ch < CH; ch++) begin
               for (int k = 0; k < 9; k++) begin
                  exp_w[ch*9*DW + k*DW +: DW] = img[m_row - 2 + k/3][m_col - 2 + k%3][ch*DW +: DW];
               end
            end
         end
         exp_fd = (m_row == H-1) && (m_col == W-1);
         m_col++;
         if (m_col == W) begin
            m_col = 0;
            m_row++;
            if (m_row == H) m_row = 0;
         end
      end
      @(negedge clk);
      chk("valid_s1", bus1.out_valid, exp_v1);
      chk("valid_s2", bus2.out_valid, exp_v2);
      chk("fdone_s1", bus1.frame_done, exp_fd);
      chk("fdone_s2", bus2.frame_done, exp_fd);
      if (exp_wchk) begin
         for (int ch = 0; ch < CH; ch++) begin
            chk("win_s1", bus1.out_window[ch*9*DW +: 9*DW], exp_w[ch*9*DW +: 9*DW]);
            chk("win_s2", bus2.out_window[ch*9*DW +: 9*DW], exp_w[ch*9*DW +: 9*DW]);
         end
      end
      if (bus1.out_valid) begin
         pulses1++;
         if (pulses1 == 1) first_w1 = bus1.out_window;
      end
      if (bus2.out_valid) begin
         pulses2++;
         if (pulses2 == 2) second_w2 = bus2.out_window;
      end
   endtask

   task automatic frame(input int off, input int maxgap, input int nbeats, input bit rnd);
      int n = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (n == nbeats) return;
            repeat ($urandom_range(maxgap, 0)) step(1'b0, 1'b0, rpx());
            step(1'b1, 1'b0, rnd ? rpx() : pix(r, c, off));
            n++;
         end
      end
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_cnt_s1"}, pulses1, 36);
      chk({tag, "_cnt_s2"}, pulses2, 9);
   endtask

   initial begin
      // reset with random inputs
      rstn = 1'b0;
      repeat (4) step(1'($urandom_range(1, 0)), 1'b0, rpx());
      rstn = 1'b1;

      // stride-1 / stride-2 golden frame, no gaps
      pulses1 = 0; pulses2 = 0;
      frame(0, 0, W*H, 1'b0);
      check_counts("golden");
      for (int k = 0; k < 9; k++) begin
         chk("first_c0", first_w1[k*DW +: DW], taps0[k]);
         chk("first_c3", first_w1[3*9*DW + k*DW +: DW], taps0[k] + 3);
         chk("s2_second_c0", second_w2[k*DW +: DW], taps0[k] + 2);
      end

      // random gaps
      pulses1 = 0; pulses2 = 0;
      frame(0, 5, W*H, 1'b0);
      check_counts("gaps");

      // soft_clr together with beat 30, then a full frame
      frame(0, 0, 30, 1'b0);
      step(1'b1, 1'b1, pix(3, 6, 0));
      pulses1 = 0; pulses2 = 0;
      frame(0, 0, W*H, 1'b0);
      check_counts("sclr");
      for (int k = 0; k < 9; k++) begin
         chk("sclr_first_c0", first_w1[k*DW +: DW], taps0[k]);
      end

      // back-to-back frames, second one offset by 64
      frame(0, 0, W*H, 1'b0);
      pulses1 = 0; pulses2 = 0;
      frame(64, 0, W*H, 1'b0);
      check_counts("b2b");
      for (int k = 0; k < 9; k++) begin
         chk("b2b_first_c0", first_w1[k*DW +: DW], taps0[k] + 64);
      end

      // async reset mid-frame, then a fresh frame
      frame(0, 0, 21, 1'b0);
      rstn = 1'b0;
      #1;
      chk("arst_valid", bus1.out_valid, 1'b0);
      chk("arst_fdone", bus1.frame_done, 1'b0);
      chk("arst_win", bus1.out_window[127:0], 128'h0);
      repeat (2) step(1'b1, 1'b0, rpx());
      rstn = 1'b1;
      pulses1 = 0; pulses2 = 0;
      frame(0, 0, W*H, 1'b0);
      check_counts("arst");

      // random data with random gaps
      pulses1 = 0; pulses2 = 0;
      frame(0, 3, W*H, 1'b1);
      check_counts("rnd");
      repeat (3) step(1'b0, 1'b0, rpx());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dw_window_gen.md
# dw_window_gen

Sliding-window generator that feeds a depthwise 3x3 convolution layer. It accepts a raster-order stream of multi-channel pixels, one pixel per beat, and buffers the two previous image rows in line buffers. For every valid 3x3 window position ("valid" convolution, no padding, stride 1 or 2), it emits a flat `9*CH*DW`-bit window. It is the producer for the depthwise layer's `valid`/`input_act` port and consumes the packed `CH*DW` activation format that the previous layer outputs.

## Interface
- `CH`, 16, channels per pixel.
- `DW`, 8, bits per activation.
- `IMG_W`, 8, image width in pixels (>= 3).
- `IMG_H`, 8, image height in rows (>= 3).
- `STRIDE`, 1, window stride, 1 or 2; same in both dimensions.
- `clk`  in  1  clock; all logic is rising-edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `soft_clr`  in  1  synchronous frame restart.
- `in_valid`  in  1  pixel beat present; accepted every cycle it is high (no backpressure).
- `in_act`  in  CH*DW  pixel; channel c at `[c*DW+DW-1 : c*DW]`.
- `out_valid`  out  1  one-cycle pulse, window on `out_window` is valid.
- `out_window`  out  9*CH*DW  window; channel c occupies `[c*9*DW+9*DW-1 : c*9*DW]`, tap k at `[c*9*DW+k*DW+DW-1 : c*9*DW+k*DW]`.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- **Counters.** `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the next pixel to be accepted. They advance only on accepted beats.
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - `row` wraps to 0 at IMG_H-1 when `col` also wraps. That end-of-frame beat sets `frame_done`.
- **Line buffers.**
  - Two arrays of IMG_W entries, each CH*DW bits: `lb0` holds row r-1 and `lb1` holds row r-2.
  - On accepting pixel p at (r,c): read `lb1[c]` and `lb0[c]` first, then write `lb1[c] <= lb0[c]` and `lb0[c] <= p`, all in the same edge.
  - Contents are not reset and are don't-care until written.
- **Window registers.** `win[ky][kx]` with ky, kx in 0..2.
  - On accept, each row shifts left: `win[ky][0] <= win[ky][1]` and `win[ky][1] <= win[ky][2]`.
  - The new column is loaded as `win[0][2] <= lb1[c]`, `win[1][2] <= lb0[c]`, `win[2][2] <= p`.
  - `out_window` is driven directly from `win`, with tap k = ky*3+kx. Tap 0 is the top-left (oldest row, oldest column) and tap 8 is the bottom-right (current pixel).
- **Emission.** An accepted beat at (r,c) produces a window when all of the following hold:
  - r >= 2 and c >= 2;
  - for STRIDE=2, additionally (r-2) and (c-2) are both even.
- **Windows per frame.**
  - STRIDE=1: (IMG_W-2)*(IMG_H-2).
  - STRIDE=2: ((IMG_W-3)/2+1)*((IMG_H-3)/2+1), integer division.
- **Row and frame boundaries.** Windows never straddle a row wrap or a frame boundary. Stale columns from the previous row are fully replaced by c=2, and emission is suppressed for r<2 in each new frame.
- **Channel independence.** Channels are handled identically and independently; no arithmetic is performed on data.
- **soft_clr.**
  - Sets `row`, `col`, `out_valid` and `frame_done` to 0 on the next edge.
  - When asserted together with `in_valid`, `soft_clr` wins and the beat is dropped.
  - `win` and the line buffers are left unchanged.
- **Reset (`rstn` low).**
  - `out_valid`=0, `frame_done`=0, `out_window`=0 (window registers cleared), `row`=`col`=0.
  - Assertion mid-frame abandons the frame. The first beat after release is pixel (0,0).

## Timing
- Latency is 1 cycle. `out_valid` goes high in the cycle after the edge that accepts the window-completing pixel, and `out_window` holds that window during that cycle.
- `out_window` may change on any subsequent accept. The consumer must capture it during the `out_valid` cycle.
- `frame_done` rises in the cycle after the edge that accepts pixel (IMG_H-1, IMG_W-1). It coincides with that beat's `out_valid`, if that beat emits one.
- Gaps on `in_valid` of any length are allowed. Outputs depend only on the accepted-beat sequence.
- Full throughput is 1 pixel per cycle, so back-to-back `out_valid` pulses occur. There is no stall state.
- The next frame may start on the beat immediately after the last pixel of the previous frame.

## Test plan
1. **Reset values.** Assert `rstn`=0 with random inputs -> `out_valid`, `frame_done` and `out_window` are all 0; after release, no output until 19 beats are accepted (8x8 frame, stride 1).
2. **Stride-1 golden frame.**
   - Stimulus: 8x8 frame, stride 1, `in_valid` held high; channel c of pixel (r,col) = (8r+col+c) mod 128.
   - First `out_valid` is 1 cycle after the 19th accept, with channel 0 taps = 0,1,2,8,9,10,16,17,18 and channel 3 taps = 3,4,5,11,12,13,19,20,21.
   - Exactly 36 pulses; `frame_done` pulses once, in the same cycle as the 36th `out_valid`.
3. **Random gaps.** Same frame as test 2 with random `in_valid` gaps (0–5 idle cycles) -> identical window sequence to test 2; each pulse follows its completing accept by exactly 1 cycle.
4. **Stride 2.** Same data as test 2 with STRIDE=2 -> exactly 9 windows; the second window (at (2,4)) has channel 0 taps = 2,3,4,10,11,12,18,19,20; no window at odd offsets.
5. **soft_clr mid-frame.** Assert `soft_clr` together with `in_valid` at beat 30, then send a full frame -> that beat is dropped; output matches test 2 exactly, with no window mixing pre-clear data.
6. **Back-to-back frames and reset mid-frame.**
   - Two consecutive frames with no gap, the second using values +64 -> the second frame's first window has channel 0 taps = 64,65,66,72,73,74,80,81,82.
   - Async reset during the second frame, followed by a fresh frame -> matches test 2.
